game_state_ctrl: RTL and testbench
==================================

# game_state_ctrl

Top-level game flow controller for the 6-track rhythm game. It turns the raw start and pause push-buttons, plus a song-finished pulse, into the 4-bit `game_state` bus. That bus is consumed by the music player, the note/track renderer and the scorer. It also keeps a millisecond play-time counter that freezes while paused, so downstream stages share one song clock.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency.
- `MS_CYCLES`, CLK_HZ/1000: clock cycles per play-time millisecond.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples needed to accept a button level (10 ms).
- `END_HOLD_MS`, 5000: time in ENDING before the block returns to BEGINNING on its own.

Ports:
- `clk` in 1: system clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `btn_start` in 1: raw, asynchronous start/confirm button, active-high.
- `btn_pause` in 1: raw, asynchronous pause/resume button, active-high.
- `song_done` in 1: one-cycle pulse, synchronous to `clk`, marking the last chart note finished.
- `game_state` out 4: 0 = BEGINNING, 1 = INGAME, 2 = HALT, 3 = ENDING. Values 4–15 are never driven.
- `state_entry` out 1: one-cycle pulse on the first cycle of each new `game_state` value.
- `play_ms` out 32: elapsed play time in milliseconds.

## Operation
- Each button passes through its own debouncer:
  - 2-FF synchronizer, then a stable-level register.
  - A counter runs while the synchronized sample differs from the stable level and clears whenever the two agree.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips.
  - A rising edge of the stable level gives a registered one-cycle `press` pulse.
  - Releases produce no pulse.
- FSM transitions, evaluated on the press pulses:
  - BEGINNING: start press → INGAME. Pause press is ignored.
  - INGAME: `song_done` → ENDING, else pause press → HALT. Start press is ignored. If `song_done` and a pause press arrive in the same cycle, `song_done` wins.
  - HALT: start press or pause press → INGAME (resume). If both arrive in the same cycle, it resumes once. `song_done` is ignored.
  - ENDING: start press → BEGINNING. Otherwise the hold timer reaching END_HOLD_MS → BEGINNING.
- `play_ms` and its prescaler:
  - Both are cleared while in BEGINNING.
  - In INGAME, the prescaler counts 0..MS_CYCLES-1; on wrap, `play_ms` increments.
  - `play_ms` saturates at 32'hFFFF_FFFF.
  - In HALT and ENDING, both are held. The prescaler keeps its partial count across a pause, so no time is lost or gained.
- ENDING hold timer:
  - A separate ms prescaler plus a ms counter, cleared on entry to ENDING.
  - Counts only in ENDING.
  - Leaves ENDING on the cycle the counter equals END_HOLD_MS.
- BEGINNING always lasts at least one cycle, because every path into it is a registered transition. This guarantees downstream stages see their reset state.

## Timing
- Reset values: `game_state` = 0 (BEGINNING), `state_entry` = 0, `play_ms` = 0; debouncer stable levels = 0; all counters = 0.
- A button held high through reset release is treated as a new press once debounced.
- Button latency: `game_state` changes exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples the raw button high. This is 2 sync stages, DEBOUNCE_CYCLES of debounce, 1 cycle for the press register and 1 for the state register.
- `song_done` latency: `game_state` = ENDING on the edge following the `song_done` cycle.
- `state_entry` is high in the same cycle the new `game_state` value first appears.
- The first `play_ms` increment occurs MS_CYCLES cycles after `game_state` becomes INGAME from BEGINNING.
- Button bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- Asserting reset mid-operation returns the block to BEGINNING immediately and asynchronously. No `state_entry` pulse is issued for that transition.

## Structure
- Shared package `game_pkg`:
  - state encodings ST_BEGINNING/ST_INGAME/ST_HALT/ST_ENDING, 4-bit;
  - the `game_state_t` width constant.
- Music player, renderer and scorer also import `game_pkg`.
- Sub-module `btn_debounce` (params DEBOUNCE_CYCLES; ports `clk`, `rst`, `btn_raw`, `level`, `press`), instantiated twice.
- FSM and timers stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, MS_CYCLES=10, END_HOLD_MS=3.
- Start from reset: raise `btn_start` → `game_state` goes 0→1 exactly 8 edges later with `state_entry` pulsing once; `play_ms` reads 1 after a further 10 cycles and 5 after 50.
- Bounce rejection: toggle `btn_start` with 2-cycle glitches for 40 cycles → `game_state` stays 0 and `press` never fires.
- Pause/resume: in INGAME at `play_ms`=3 plus 4 prescaler cycles, press pause → HALT, with `play_ms` frozen at 3 for 100 cycles; press start → INGAME, and `play_ms` becomes 4 exactly 6 cycles after re-entry.
- Simultaneous events: pulse `song_done` in the same cycle as a pause press → next state is 3 (ENDING), not 2; `song_done` pulsed in HALT → state stays 2.
- ENDING timeout and exit: enter ENDING and wait 30 cycles → state returns to 0, `play_ms` clears to 0; a start press in ENDING before timeout → 0 immediately after the press latency.
- Async reset mid-HALT: assert `rst` between clock edges → `game_state`=0 and `play_ms`=0 before the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow definitions used by the controller, music player,
// renderer and scorer.
package game_pkg;

  localparam int unsigned GAME_STATE_W = 4;

  typedef enum logic [GAME_STATE_W-1:0] {
    ST_BEGINNING = 4'd0,
    ST_INGAME    = 4'd1,
    ST_HALT      = 4'd2,
    ST_ENDING    = 4'd3
  } game_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debouncer and
// a registered one-cycle pulse on each accepted press (releases are silent).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Flip the stable level once the sample has disagreed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 != level) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // One-cycle pulse on a rising edge of the stable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: debounced start/pause buttons and song_done drive
// the BEGINNING/INGAME/HALT/ENDING state, plus a pausable ms play clock.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned MS_CYCLES       = CLK_HZ / 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned END_HOLD_MS     = 5000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_start,
  input  logic                    btn_pause,
  input  logic                    song_done,
  output logic [GAME_STATE_W-1:0] game_state,
  output logic                    state_entry,
  output logic [31:0]             play_ms
);

  localparam int unsigned PRE_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam int unsigned END_W = $clog2(END_HOLD_MS + 1);

  game_state_t      state;
  game_state_t      state_next;
  logic             start_press;
  logic             pause_press;
  logic             start_level_unused;
  logic             pause_level_unused;
  logic [PRE_W-1:0] play_pre;
  logic [31:0]      play_cnt;
  logic [PRE_W-1:0] end_pre;
  logic [END_W-1:0] end_ms;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .level   (start_level_unused),
    .press   (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_pause),
    .level   (pause_level_unused),
    .press   (pause_press)
  );

  // State register; state_entry marks the first cycle of every new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BEGINNING;
      state_entry <= 1'b0;
    end else begin
      state       <= state_next;
      state_entry <= (state_next != state);
    end
  end

  // Next-state logic; song_done has priority over pause in INGAME.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_BEGINNING: if (start_press) state_next = ST_INGAME;
      ST_INGAME: begin
        if (song_done)        state_next = ST_ENDING;
        else if (pause_press) state_next = ST_HALT;
      end
      ST_HALT:      if (start_press || pause_press) state_next = ST_INGAME;
      ST_ENDING:    if (start_press || end_ms == END_W'(END_HOLD_MS)) state_next = ST_BEGINNING;
      default:      state_next = ST_BEGINNING;
    endcase
  end

  // Play clock: cleared in BEGINNING, runs in INGAME, holds its partial count otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      play_pre <= '0;
      play_cnt <= '0;
    end else if (state == ST_BEGINNING) begin
      play_pre <= '0;
      play_cnt <= '0;
    end else if (state == ST_INGAME) begin
      if (play_pre == PRE_W'(MS_CYCLES - 1)) begin
        play_pre <= '0;
        if (play_cnt != '1) play_cnt <= play_cnt + 1'b1;
      end else begin
        play_pre <= play_pre + 1'b1;
      end
    end
  end

  // ENDING hold timer; held at zero outside ENDING so each entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_pre <= '0;
      end_ms  <= '0;
    end else if (state != ST_ENDING) begin
      end_pre <= '0;
      end_ms  <= '0;
    end else if (end_pre == PRE_W'(MS_CYCLES - 1)) begin
      end_pre <= '0;
      if (end_ms != END_W'(END_HOLD_MS)) end_ms <= end_ms + 1'b1;
    end else begin
      end_pre <= end_pre + 1'b1;
    end
  end

  assign game_state = state;
  assign play_ms    = play_cnt;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus randomized buttons and
// song_done, compared every cycle against a behavioural model.
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int unsigned DB   = 4;
  localparam int unsigned MS   = 10;
  localparam int unsigned HOLD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start;
  logic        btn_pause;
  logic        song_done;
  logic [3:0]  game_state;
  logic        state_entry;
  logic [31:0] play_ms;

  int unsigned nchecks = 0;
  int unsigned nerrors = 0;

  always #5 clk = ~clk;

  game_state_ctrl #(
    .CLK_HZ          (10_000),
    .MS_CYCLES       (MS),
    .DEBOUNCE_CYCLES (DB),
    .END_HOLD_MS     (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .song_done   (song_done),
    .game_state  (game_state),
    .state_entry (state_entry),
    .play_ms     (play_ms)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buttons: level flips when the last DB synchronized samples all disagree with it.
  bit              hs[$];
  bit              hp[$];
  int              m_state;
  bit              m_entry;
  longint unsigned m_play_cyc;
  longint unsigned m_end_cyc;
  bit              m_lvl[2];
  bit              m_lvl_prev[2];
  bit              m_press[2];

  function automatic bit window_flip(input bit h[$], input bit lvl);
    for (int k = 0; k < int'(DB); k++)
      if (h[h.size() - 3 - k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int ns;
    bit nl0, nl1;
    if (rst) begin
      hs.delete();
      hp.delete();
      for (int i = 0; i < int'(DB) + 2; i++) begin
        hs.push_back(1'b0);
        hp.push_back(1'b0);
      end
      m_state = 0; m_entry = 0; m_play_cyc = 0; m_end_cyc = 0;
      for (int b = 0; b < 2; b++) begin
        m_lvl[b] = 0; m_lvl_prev[b] = 0; m_press[b] = 0;
      end
    end else begin
      hs.push_back(btn_start);
      hp.push_back(btn_pause);
      if (hs.size() > 32) begin
        void'(hs.pop_front());
        void'(hp.pop_front());
      end
      nl0 = window_flip(hs, m_lvl[0]) ? ~m_lvl[0] : m_lvl[0];
      nl1 = window_flip(hp, m_lvl[1]) ? ~m_lvl[1] : m_lvl[1];
      ns = m_state;
      case (m_state)
        0: if (m_press[0]) ns = 1;
        1: if (song_done) ns = 3; else if (m_press[1]) ns = 2;
        2: if (m_press[0] || m_press[1]) ns = 1;
        3: if (m_press[0] || (m_end_cyc / MS) == HOLD) ns = 0;
        default: ns = 0;
      endcase
      if (m_state == 0) m_play_cyc = 0;
      else if (m_state == 1) m_play_cyc++;
      if (m_state == 3) m_end_cyc++;
      else m_end_cyc = 0;
      m_entry = (ns != m_state);
      m_state = ns;
      for (int b = 0; b < 2; b++) begin
        m_press[b]    = m_lvl[b] & ~m_lvl_prev[b];
        m_lvl_prev[b] = m_lvl[b];
      end
      m_lvl[0] = nl0;
      m_lvl[1] = nl1;
    end
  end

  // Continuous comparison away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("state", game_state, m_state);
      check_eq("entry", state_entry, m_entry);
      check_eq("play_ms", play_ms, 32'(m_play_cyc / MS));
      check_eq("start_press", dut.u_start_db.press, m_press[0]);
      check_eq("pause_press", dut.u_pause_db.press, m_press[1]);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    song_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_state(input string tag, input int target, input int limit, output int n);
    n = 0;
    while (game_state != 4'(target) && n < limit) begin
      tick();
      n++;
    end
    if (game_state != 4'(target)) check_eq(tag, game_state, target);
  endtask

  int n;
  int fires;
  int hold_s, hold_p;

  initial begin
    rst = 1'b1;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    song_done = 1'b0;
    #2;
    check_eq("rst_state", game_state, 0);
    check_eq("rst_play", play_ms, 0);
    check_eq("rst_entry", state_entry, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Start from reset.
    btn_start = 1'b1;
    wait_state("to_ingame", 1, 40, n);
    check_eq("start_latency", n, 8);
    check_eq("entry_on_start", state_entry, 1);
    btn_start = 1'b0;
    tick();
    check_eq("entry_once", state_entry, 0);
    repeat (9) tick();
    check_eq("play_after_10", play_ms, 1);
    repeat (40) tick();
    check_eq("play_after_50", play_ms, 5);

    // Bounce rejection.
    do_reset();
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      btn_start = 1'b1;
      repeat (2) begin tick(); if (dut.u_start_db.press) fires++; end
      btn_start = 1'b0;
      repeat (2) begin tick(); if (dut.u_start_db.press) fires++; end
    end
    repeat (10) begin tick(); if (dut.u_start_db.press) fires++; end
    check_eq("bounce_press", fires, 0);
    check_eq("bounce_state", game_state, 0);

    // Pause at play_ms=3 with 4 prescaler cycles, then resume.
    do_reset();
    btn_start = 1'b1;
    wait_state("to_ingame2", 1, 40, n);
    btn_start = 1'b0;
    repeat (26) tick();
    btn_pause = 1'b1;
    repeat (8) tick();
    check_eq("halt_state", game_state, 2);
    check_eq("halt_play", play_ms, 3);
    btn_pause = 1'b0;
    repeat (100) tick();
    check_eq("halt_frozen", play_ms, 3);
    check_eq("halt_held", game_state, 2);
    btn_start = 1'b1;
    wait_state("resume", 1, 40, n);
    check_eq("resume_latency", n, 8);
    btn_start = 1'b0;
    repeat (5) tick();
    check_eq("resume_play_5", play_ms, 3);
    tick();
    check_eq("resume_play_6", play_ms, 4);

    // song_done and pause press in the same cycle.
    repeat (4) tick();
    btn_pause = 1'b1;
    repeat (7) tick();
    check_eq("pause_pulse", dut.u_pause_db.press, 1);
    song_done = 1'b1;
    tick();
    song_done = 1'b0;
    check_eq("done_beats_pause", game_state, 3);
    btn_pause = 1'b0;

    // ENDING timeout.
    wait_state("end_timeout", 0, 100, n);
    check_eq("end_timeout_cycles", n, 31);
    tick();
    check_eq("end_play_clear", play_ms, 0);

    // song_done ignored in HALT.
    btn_start = 1'b1;
    wait_state("to_ingame3", 1, 40, n);
    btn_start = 1'b0;
    repeat (10) tick();
    btn_pause = 1'b1;
    wait_state("to_halt", 2, 40, n);
    btn_pause = 1'b0;
    tick();
    song_done = 1'b1;
    tick();
    song_done = 1'b0;
    check_eq("halt_ignores_done", game_state, 2);
    tick();
    check_eq("halt_ignores_done2", game_state, 2);

    // Start press exits ENDING before the timeout.
    btn_start = 1'b1;
    wait_state("resume2", 1, 40, n);
    btn_start = 1'b0;
    repeat (8) tick();
    song_done = 1'b1;
    tick();
    song_done = 1'b0;
    check_eq("to_ending", game_state, 3);
    btn_start = 1'b1;
    wait_state("end_by_start", 0, 40, n);
    check_eq("end_start_latency", n, 8);
    btn_start = 1'b0;

    // Asynchronous reset in HALT.
    repeat (8) tick();
    btn_start = 1'b1;
    wait_state("to_ingame4", 1, 40, n);
    btn_start = 1'b0;
    repeat (15) tick();
    btn_pause = 1'b1;
    wait_state("to_halt2", 2, 40, n);
    btn_pause = 1'b0;
    repeat (3) tick();
    check_eq("pre_rst_play", play_ms, 2);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_state", game_state, 0);
    check_eq("async_rst_play", play_ms, 0);
    check_eq("async_rst_entry", state_entry, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Randomized phase against the model.
    hold_s = 0;
    hold_p = 0;
    repeat (3000) begin
      if (hold_s == 0) begin
        btn_start = 1'($urandom_range(0, 1));
        hold_s = int'($urandom_range(1, 12));
      end else hold_s--;
      if (hold_p == 0) begin
        btn_pause = 1'($urandom_range(0, 1));
        hold_p = int'($urandom_range(1, 12));
      end else hold_p--;
      song_done = ($urandom_range(0, 29) == 0);
      tick();
    end
    song_done = 1'b0;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
